// File: rtl/prog_mem_pkg.sv
// ---------------------------------------------------------------------------
// prog_mem_pkg
// Shared types and default sizes for the program memory / loader slice.
//   state_t     : loader FSM states (RUN, LOAD, DRAIN)
//   DEF_ADDR_W  : default CPU fetch address width
//   DEF_DATA_W  : default instruction / load bus / checksum width
//   DEPTH       : default memory depth in words
//   LAST_ADDR   : default highest word address
// ---------------------------------------------------------------------------
package prog_mem_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEPTH      = 2 ** DEF_ADDR_W;
    localparam int LAST_ADDR  = DEPTH - 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/prog_mem_loader_if.sv
// ---------------------------------------------------------------------------
// prog_mem_loader_if
// Bundles the CPU fetch port and the byte-wide program load port.
//   master : host/CPU side -- drives cpu_addr, load_start, ld_valid, ld_data
//   slave  : loader side   -- drives cpu_data, cpu_n_reset, ld_ready,
//            load_busy, load_done, load_sum
// ---------------------------------------------------------------------------
interface prog_mem_loader_if
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_n_reset;
    logic              load_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              load_busy;
    logic              load_done;
    logic [DATA_W-1:0] load_sum;

    modport master (
        output cpu_addr, load_start, ld_valid, ld_data,
        input  cpu_data, cpu_n_reset, ld_ready, load_busy, load_done, load_sum
    );

    modport slave (
        input  cpu_addr, load_start, ld_valid, ld_data,
        output cpu_data, cpu_n_reset, ld_ready, load_busy, load_done, load_sum
    );

endinterface

// File: rtl/prog_mem_array.sv
// ---------------------------------------------------------------------------
// prog_mem_array
// 2**ADDR_W x DATA_W register array: synchronous write, asynchronous read,
// synchronous clear while n_reset is low.
//   clk, n_reset : clock, synchronous active-low reset (clears all words)
//   we           : write enable, samples waddr/wdata at posedge
//   waddr, wdata : write address and data
//   raddr, rdata : combinational read port
// ---------------------------------------------------------------------------
module prog_mem_array
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_mem_loader.sv
// ---------------------------------------------------------------------------
// prog_mem_loader
// Instruction memory for the CPU core plus a sequential program loader.
// The CPU reads mem[cpu_addr] combinationally; a load writes words from
// address 0 upward and keeps the CPU in reset until one cycle after the
// final write, so the core restarts at address 0 on the new program.
//   clk, n_reset : clock, synchronous active-low reset
//   bus (slave)  : cpu_addr/cpu_data fetch port, registered cpu_n_reset,
//                  load_start request, ld_valid/ld_data/ld_ready load
//                  handshake, load_busy/load_done status, load_sum checksum
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | CPU running from memory, load port closed
//   LOAD  | CPU held in reset, accepting words at wptr
//   DRAIN | one settle cycle after the last write, CPU still in reset
// ---------------------------------------------------------------------------
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input logic              clk,
    input logic              n_reset,
    prog_mem_loader_if.slave bus
);

    localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'((2 ** ADDR_W) - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              cpu_n_reset_q, cpu_n_reset_d;
    logic              done_q, done_d;
    logic              mem_we;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q       <= RUN;
            wptr_q        <= '0;
            sum_q         <= '0;
            cpu_n_reset_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            sum_q         <= sum_d;
            cpu_n_reset_q <= cpu_n_reset_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        sum_d         = sum_q;
        cpu_n_reset_d = 1'b1;
        done_d        = 1'b0;
        mem_we        = 1'b0;
        case (state_q)
            RUN: begin
                // ld_valid is deliberately ignored here, even alongside load_start
                if (bus.load_start) begin
                    state_d       = LOAD;
                    wptr_d        = '0;
                    sum_d         = '0;
                    cpu_n_reset_d = 1'b0;
                end
            end
            LOAD: begin
                cpu_n_reset_d = 1'b0;
                // ld_ready is constant high in LOAD, so ld_valid alone is a transfer
                if (bus.ld_valid) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    sum_d  = sum_q + bus.ld_data;
                    if (wptr_q == WPTR_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // cpu_n_reset_d stays at its default of 1: release on the way out
                state_d = RUN;
                done_d  = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    prog_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .n_reset (n_reset),
        .we      (mem_we),
        .waddr   (wptr_q),
        .wdata   (bus.ld_data),
        .raddr   (bus.cpu_addr),
        .rdata   (bus.cpu_data)
    );

    assign bus.ld_ready    = (state_q == LOAD);
    assign bus.load_busy   = (state_q != RUN);
    assign bus.cpu_n_reset = cpu_n_reset_q;
    assign bus.load_done   = done_q;
    assign bus.load_sum    = sum_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_loader
// Drives program loads (steady, gapped, random-valid, interrupted) into
// prog_mem_loader and compares every cycle against a word-level model of
// the memory image, checksum and CPU-hold window.
// ---------------------------------------------------------------------------
module tb_prog_mem_loader;
    import prog_mem_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    prog_mem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    prog_mem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    // CPU fetch address: either driven directly, or a counter that a real
    // instruction pointer would be (cleared while the CPU is held in reset).
    logic [AW-1:0] drv_addr = '0;
    logic [AW-1:0] cpu_ctr  = '0;
    bit            ctr_en   = 1'b0;
    assign bus.cpu_addr = ctr_en ? cpu_ctr : drv_addr;
    always @(posedge clk) cpu_ctr <= bus.cpu_n_reset ? cpu_ctr + 1'b1 : '0;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A load is "how many words of 16 have arrived"; after the 16th there is
    // one settle cycle, then the CPU is released with a done pulse.
    logic [DW-1:0] m_mem [N];
    logic [DW-1:0] m_sum;
    int            m_words;
    bit            m_loading, m_settle, m_rel, m_done, chk_en;

    always @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < N; i++) m_mem[i] = '0;
            m_sum = '0; m_words = 0;
            m_loading = 0; m_settle = 0; m_rel = 0; m_done = 0;
            chk_en = 1;
        end else if (m_settle) begin
            m_settle = 0; m_loading = 0; m_rel = 1; m_done = 1;
        end else if (m_loading) begin
            m_done = 0;
            if (bus.ld_valid) begin
                m_mem[m_words] = bus.ld_data;
                m_sum = DW'(m_sum + bus.ld_data);
                m_words++;
                if (m_words == N) begin
                    m_words = 0;
                    m_settle = 1;
                end
            end
        end else begin
            m_done = 0;
            if (bus.load_start) begin
                m_loading = 1; m_words = 0; m_sum = '0; m_rel = 0;
            end else begin
                m_rel = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_cpu_data",    bus.cpu_data,    m_mem[bus.cpu_addr]);
            check("cyc_cpu_n_reset", bus.cpu_n_reset, m_rel);
            check("cyc_ld_ready",    bus.ld_ready,    m_loading && !m_settle);
            check("cyc_load_busy",   bus.load_busy,   m_loading || m_settle);
            check("cyc_load_done",   bus.load_done,   m_done);
            check("cyc_load_sum",    bus.load_sum,    m_sum);
            if (bus.load_done === 1'b1) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    logic [DW-1:0] words [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] sum_words();
        logic [DW-1:0] s = '0;
        for (int i = 0; i < N; i++) s = DW'(s + words[i]);
        return s;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) words[i] = DW'($urandom);
    endtask

    // mode 0: ld_valid always high, 1: every other cycle, 2: random
    task automatic do_load(input int mode, input int inject_at, input int abort_at,
                           output int cycles);
        int  xfers;
        bit  v;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        xfers  = 0;
        cycles = 0;
        while (xfers < N && xfers != abort_at && cycles < 200) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cycles % 2 == 0) : 1'($urandom_range(0, 1));
            bus.ld_valid   = v;
            bus.ld_data    = v ? words[xfers] : DW'($urandom);
            bus.load_start = (xfers == inject_at);
            tick();
            cycles++;
            if (v) xfers++;
            check("load_cpu_held", bus.cpu_n_reset, 1'b0);
        end
        bus.ld_valid   = 1'b0;
        bus.load_start = 1'b0;
        if (cycles >= 200) check("load_timeout", 32'(xfers), 32'(N));
    endtask

    task automatic finish_load(input logic [DW-1:0] exp_sum, input int d0);
        check("drain_busy",  bus.load_busy,   1'b1);
        check("drain_ready", bus.ld_ready,    1'b0);
        check("drain_hold",  bus.cpu_n_reset, 1'b0);
        tick();
        check("done_pulse",   bus.load_done,   1'b1);
        check("done_release", bus.cpu_n_reset, 1'b1);
        check("done_idle",    bus.load_busy,   1'b0);
        tick();
        check("done_single",  bus.load_done,   1'b0);
        check("done_count",   32'(done_cnt - d0), 32'd1);
        check("load_sum",     bus.load_sum,    exp_sum);
    endtask

    task automatic sweep_words();
        for (int i = 0; i < N; i++) begin
            drv_addr = AW'(i);
            #1;
            check("readback", bus.cpu_data, words[i]);
        end
    endtask

    task automatic sweep_zero();
        for (int i = 0; i < N; i++) begin
            drv_addr = AW'(i);
            #1;
            check("zero_mem", bus.cpu_data, 8'h00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, d0;
        bus.load_start = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        n_reset        = 1'b0;

        // reset then idle
        tick(); tick();
        check("rst_cpu_n_reset", bus.cpu_n_reset, 1'b0);
        check("rst_ld_ready",    bus.ld_ready,    1'b0);
        check("rst_load_done",   bus.load_done,   1'b0);
        n_reset = 1'b1;
        tick();
        check("rel_cpu_n_reset", bus.cpu_n_reset, 1'b1);
        sweep_zero();
        check("idle_ld_ready",   bus.ld_ready,    1'b0);

        // back-to-back 00..0F
        for (int i = 0; i < N; i++) words[i] = DW'(i);
        d0 = done_cnt;
        do_load(0, -1, -1, cyc);
        check("b2b_cycles", 32'(cyc), 32'd16);
        finish_load(8'h78, d0);
        sweep_words();

        // ld_valid in RUN is ignored
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hAA;
        tick(); tick(); tick();
        bus.ld_valid = 1'b0;
        drv_addr = 4'd10;
        #1;
        check("ignored_valid", bus.cpu_data, 8'h0A);
        check("ignored_sum",   bus.load_sum, 8'h78);
        sweep_words();

        // gapped all-FF load, checksum wraps
        for (int i = 0; i < N; i++) words[i] = 8'hFF;
        d0 = done_cnt;
        do_load(1, -1, -1, cyc);
        check("gap_cycles", 32'(cyc), 32'd31);
        finish_load(8'hF0, d0);
        sweep_words();

        // load_start after 5 words does not restart
        fill_random();
        d0 = done_cnt;
        do_load(0, 5, -1, cyc);
        check("inject_cycles", 32'(cyc), 32'd16);
        finish_load(sum_words(), d0);
        sweep_words();

        // reset after 7 transfers
        fill_random();
        d0 = done_cnt;
        do_load(2, -1, 7, cyc);
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
        tick();
        check("abort_sum",     bus.load_sum,    8'h00);
        check("abort_busy",    bus.load_busy,   1'b0);
        check("abort_release", bus.cpu_n_reset, 1'b1);
        sweep_zero();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // full load after the aborted one
        fill_random();
        d0 = done_cnt;
        do_load(2, -1, -1, cyc);
        finish_load(sum_words(), d0);
        sweep_words();

        // CPU restart: counter-driven fetch starts at address 0
        fill_random();
        ctr_en = 1'b1;
        do_load(0, -1, -1, cyc);
        tick();
        check("restart_addr0", bus.cpu_addr,    4'd0);
        check("restart_word0", bus.cpu_data,    words[0]);
        check("restart_rel",   bus.cpu_n_reset, 1'b1);
        tick();
        check("restart_addr1", bus.cpu_addr,    4'd1);
        check("restart_word1", bus.cpu_data,    words[1]);
        ctr_en = 1'b0;

        // random loads
        for (int k = 0; k < 4; k++) begin
            fill_random();
            d0 = done_cnt;
            do_load($urandom_range(0, 2), $urandom_range(0, 20), -1, cyc);
            finish_load(sum_words(), d0);
            sweep_words();
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Instruction memory and loader that sits directly upstream of the CPU core.
- It answers the CPU's fetch address with an instruction word, combinationally, in the same cycle.
- It also accepts a new program over a byte-wide valid/ready load port, writing words sequentially from address 0.
- While loading, it holds the CPU in reset and releases it only after the last word is written, so the CPU restarts at address 0 on the new program.

Parameters:
- ADDR_W, 4, width of the CPU fetch address; memory depth is 2**ADDR_W words.
- DATA_W, 8, instruction word width; also the width of the load bus and the checksum.

Ports:
- clk  input  1  clock.
- n_reset  input  1  reset: synchronous, active-low.
- cpu_addr  input  ADDR_W  fetch address from the CPU instruction pointer.
- cpu_data  output  DATA_W  instruction word at cpu_addr.
- cpu_n_reset  output  1  registered active-low reset to the CPU core.
- load_start  input  1  single-cycle request to begin a program load.
- ld_valid  input  1  load word valid.
- ld_data  input  DATA_W  load word.
- ld_ready  output  1  loader accepts ld_data this cycle.
- load_busy  output  1  high while a load is in progress (LOAD or DRAIN).
- load_done  output  1  one-cycle pulse when a load completes.
- load_sum  output  DATA_W  modulo-2**DATA_W sum of the words of the most recent load.

Behaviour:
- Reset (n_reset low at posedge):
  - all memory words cleared to 0;
  - state RUN, wptr=0, load_sum=0;
  - cpu_n_reset=0, ld_ready=0, load_busy=0, load_done=0.
- First posedge with n_reset high: cpu_n_reset goes to 1 (state RUN).
- Read path: cpu_data = mem[cpu_addr], combinational, zero latency, in every state. Contents during LOAD are don't-care to the CPU because it is held in reset.
- States: RUN, LOAD, DRAIN.
- RUN:
  - cpu_n_reset=1, ld_ready=0; ld_valid is ignored.
  - load_start=1 → LOAD next cycle, with wptr<=0, load_sum<=0, cpu_n_reset<=0.
- LOAD:
  - ld_ready=1, load_busy=1, cpu_n_reset=0.
  - Transfer occurs when ld_valid & ld_ready at the posedge: mem[wptr]<=ld_data, load_sum<=load_sum+ld_data (truncated to DATA_W), wptr<=wptr+1.
  - ld_valid low: no write, no state change; gaps of any length are allowed.
  - Transfer with wptr==2**ADDR_W-1 → DRAIN; wptr wraps to 0.
  - load_start while in LOAD or DRAIN is ignored; it does not restart the load.
- DRAIN (exactly one cycle):
  - ld_ready=0, cpu_n_reset=0, load_busy=1.
  - → RUN, with cpu_n_reset<=1 and load_done<=1 for exactly one cycle.
  - This guarantees the CPU sees at least one reset cycle after the final write, and its first fetch after release is address 0.
- load_sum holds its value in RUN until the next load_start.
- Reset mid-load: memory cleared, state RUN, wptr 0, load_sum 0; no load_done pulse. Partially loaded words are lost.
- load_start together with ld_valid in RUN: only load_start acts; that ld_data is not written.
- ld_ready is a function of state only, never of ld_valid.

Decomposition:
- Package prog_mem_pkg holds:
  - state enum {RUN, LOAD, DRAIN};
  - default ADDR_W/DATA_W localparams;
  - DEPTH = 2**ADDR_W;
  - LAST_ADDR = DEPTH-1.
- One sub-module, prog_mem_array:
  - DEPTH x DATA_W register array;
  - synchronous write enable, asynchronous read, synchronous clear on n_reset.
- The FSM, write pointer and checksum stay in prog_mem_loader.

Test Plan:
- Reset then idle: hold n_reset low 2 cycles, release → cpu_n_reset 0 during reset and 1 on the first cycle after; cpu_data=8'h00 for all 16 cpu_addr values; ld_ready=0.
- Back-to-back load: pulse load_start, then drive words 8'h00..8'h0F with ld_valid held high → 16 transfers in 16 cycles; DRAIN lasts 1 cycle; load_done pulses once; load_sum=8'h78; mem[i]=i on readback.
- Gapped load: words 8'hFF x16 with ld_valid toggled every other cycle → exactly 16 writes; load_sum=8'hF0 (wrap); cpu_n_reset stays 0 from the cycle after load_start through DRAIN.
- Ignored requests: in RUN, ld_valid=1 with ld_data=8'hAA → memory unchanged. load_start mid-LOAD after 5 words → wptr continues at 5, no restart.
- Reset mid-load: assert n_reset after 7 transfers → memory all 0, state RUN, load_sum=0, no load_done. A subsequent full load succeeds.
- CPU restart: after load, with cpu_addr driven by a 4-bit counter reset by cpu_n_reset → first fetch after release is cpu_addr=0, returning the first loaded word.
